// File: rtl/dense_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dense_pkg                                                                |
// | Shared field-width defaults and bundle-width helper for the dense pipe.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dense_pkg;

  localparam int COST_TYPE_SIZE  = 8;
  localparam int DENSE_TYPE_SIZE = 4;
  localparam int ACT_TYPE_SIZE   = 4;
  localparam int INDEX_SIZE      = 32;

  // Bundle order, MSB first: act_type, backprop_cost, cost_type, is_update,
  // predict_value, w_layer_index, w_row_index, dense_type, x, w.
  function automatic int bundle_width(input int size, input int data_size,
                                      input int cost_w, input int dense_w,
                                      input int act_w);
    return act_w + data_size + cost_w + 1 + data_size * size
         + 2 * INDEX_SIZE + dense_w + 2 * data_size * size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dense_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dense_pipe_stage                                                         |
// | One elastic stage: valid bit, payload register and ready logic.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dense_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  // An empty stage always accepts, so bubbles close even under backpressure.
  assign up_ready = !r_valid || down_ready;
  assign w_load   = up_valid && up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (w_load)
        r_valid <= 1'b1;
      else if (down_ready)
        r_valid <= 1'b0;
      if (w_load)
        r_data <= up_data;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/dense_layer_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dense_layer_pipe_reg                                                     |
// | Elastic valid/ready pipeline carrying the dense-layer field bundle.      |
// | Optional macro DENSE_PIPE_PERF_EN adds the stall_count output.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dense_layer_pipe_reg
  import dense_pkg::*;
#(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int cost_type_size  = COST_TYPE_SIZE,
  parameter int dense_type_size = DENSE_TYPE_SIZE,
  parameter int act_type_size   = ACT_TYPE_SIZE,
  parameter int depth           = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [act_type_size-1:0]      act_type,
  input  logic [data_size-1:0]          backprop_cost,
  input  logic [cost_type_size-1:0]     cost_type,
  input  logic                          is_update,
  input  logic [data_size*size-1:0]     predict_value,
  input  logic [31:0]                   w_layer_index,
  input  logic [31:0]                   w_row_index,
  input  logic [dense_type_size-1:0]    dense_type,
  input  logic [data_size*size-1:0]     x,
  input  logic [data_size*size-1:0]     w,
  output logic [act_type_size-1:0]      act_type_out,
  output logic [data_size-1:0]          backprop_cost_out,
  output logic [cost_type_size-1:0]     cost_type_out,
  output logic                          is_update_out,
  output logic [data_size*size-1:0]     predict_value_out,
  output logic [31:0]                   w_layer_index_out,
  output logic [31:0]                   w_row_index_out,
  output logic [dense_type_size-1:0]    dense_type_out,
  output logic [data_size*size-1:0]     x_out,
  output logic [data_size*size-1:0]     w_out,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush,
  output logic [$clog2(depth+1)-1:0]    occupancy
`ifdef DENSE_PIPE_PERF_EN
  ,
  output logic [31:0]                   stall_count
`endif
);

  localparam int BW    = bundle_width(size, data_size, cost_type_size,
                                      dense_type_size, act_type_size);
  localparam int OCC_W = $clog2(depth + 1);

  // Index 0 is the upstream interface, index depth the downstream one.
  logic [depth:0]  w_vchain;
  logic [depth:0]  w_rchain;
  logic [BW-1:0]   w_dchain [0:depth];
  logic [OCC_W-1:0] w_occupancy;

  assign w_vchain[0] = in_valid;
  assign w_dchain[0] = {act_type, backprop_cost, cost_type, is_update,
                        predict_value, w_layer_index, w_row_index,
                        dense_type, x, w};
  assign w_rchain[depth] = out_ready;

  for (genvar k = 0; k < depth; k++) begin : g_stage
    dense_pipe_stage #(
      .WIDTH(BW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .up_valid   (w_vchain[k]),
      .up_ready   (w_rchain[k]),
      .up_data    (w_dchain[k]),
      .down_ready (w_rchain[k+1]),
      .valid      (w_vchain[k+1]),
      .data       (w_dchain[k+1])
    );
  end

  assign in_ready  = w_rchain[0];
  assign out_valid = w_vchain[depth];
  assign {act_type_out, backprop_cost_out, cost_type_out, is_update_out,
          predict_value_out, w_layer_index_out, w_row_index_out,
          dense_type_out, x_out, w_out} = w_dchain[depth];

  // Population count of the stage valid flops.
  always_comb begin
    w_occupancy = '0;
    for (int i = 1; i <= depth; i++)
      w_occupancy = w_occupancy + OCC_W'(w_vchain[i]);
  end

  assign occupancy = w_occupancy;

`ifdef DENSE_PIPE_PERF_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= '0;
    else if (flush)
      r_stall_count <= '0;
    else if (out_valid && !out_ready && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dense_layer_pipe_reg                                                  |
// | Directed bench: depth-2 and depth-3 instances of dense_layer_pipe_reg.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dense_layer_pipe_reg;

  typedef struct packed {
    logic [3:0]  act;
    logic [15:0] bc;
    logic [7:0]  ct;
    logic        upd;
    logic [47:0] pv;
    logic [31:0] li;
    logic [31:0] ri;
    logic [3:0]  dt;
    logic [47:0] x;
    logic [47:0] w;
  } bundle_t;

  typedef struct {
    logic        iv;
    logic [47:0] xv;
    logic        exp_ready;
    logic        exp_valid;
    logic [47:0] exp_x;
  } stream_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  bundle_t in_b = '0;
  logic iv2 = 1'b0, iv3 = 1'b0, or2 = 1'b1, or3 = 1'b0;
  logic ir2, ir3, ov2, ov3;
  logic [1:0] occ2, occ3;

  logic [3:0]  act2, act3, dt2, dt3;
  logic [15:0] bc2, bc3;
  logic [7:0]  ct2, ct3;
  logic        upd2, upd3;
  logic [47:0] pv2, pv3, x2, x3, w2, w3;
  logic [31:0] li2, li3, ri2, ri3;
  bundle_t out2, out3;
`ifdef DENSE_PIPE_PERF_EN
  logic [31:0] sc2, sc3;
`endif

  int vectors = 0;
  int miscompares = 0;

  assign out2 = {act2, bc2, ct2, upd2, pv2, li2, ri2, dt2, x2, w2};
  assign out3 = {act3, bc3, ct3, upd3, pv3, li3, ri3, dt3, x3, w3};

  always #5 clk = ~clk;

  dense_layer_pipe_reg #(.size(3), .data_size(16), .depth(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .act_type(in_b.act), .backprop_cost(in_b.bc), .cost_type(in_b.ct),
    .is_update(in_b.upd), .predict_value(in_b.pv), .w_layer_index(in_b.li),
    .w_row_index(in_b.ri), .dense_type(in_b.dt), .x(in_b.x), .w(in_b.w),
    .act_type_out(act2), .backprop_cost_out(bc2), .cost_type_out(ct2),
    .is_update_out(upd2), .predict_value_out(pv2), .w_layer_index_out(li2),
    .w_row_index_out(ri2), .dense_type_out(dt2), .x_out(x2), .w_out(w2),
    .in_valid(iv2), .in_ready(ir2), .out_valid(ov2), .out_ready(or2),
    .flush(flush), .occupancy(occ2)
`ifdef DENSE_PIPE_PERF_EN
    , .stall_count(sc2)
`endif
  );

  dense_layer_pipe_reg #(.size(3), .data_size(16), .depth(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .act_type(in_b.act), .backprop_cost(in_b.bc), .cost_type(in_b.ct),
    .is_update(in_b.upd), .predict_value(in_b.pv), .w_layer_index(in_b.li),
    .w_row_index(in_b.ri), .dense_type(in_b.dt), .x(in_b.x), .w(in_b.w),
    .act_type_out(act3), .backprop_cost_out(bc3), .cost_type_out(ct3),
    .is_update_out(upd3), .predict_value_out(pv3), .w_layer_index_out(li3),
    .w_row_index_out(ri3), .dense_type_out(dt3), .x_out(x3), .w_out(w3),
    .in_valid(iv3), .in_ready(ir3), .out_valid(ov3), .out_ready(or3),
    .flush(flush), .occupancy(occ3)
`ifdef DENSE_PIPE_PERF_EN
    , .stall_count(sc3)
`endif
  );

  // Every field is a distinct function of the seed so a swapped field shows.
  function automatic bundle_t make_bundle(input logic [47:0] v);
    bundle_t b;
    b.act = v[3:0] ^ 4'h5;
    b.bc  = v[15:0] + 16'h1000;
    b.ct  = v[7:0] ^ 8'hA5;
    b.upd = v[0];
    b.pv  = {v[15:0], 16'hBEEF, ~v[15:0]};
    b.li  = 32'h1000_0000 | v[31:0];
    b.ri  = ~v[31:0];
    b.dt  = v[3:0] + 4'd3;
    b.x   = v;
    b.w   = {~v[15:0], v[31:0]};
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input bundle_t act, input bundle_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  stream_vec_t sv [7];
  int next_x;
  int accepted;
  int emitted;
  int seen;
  logic acc;

  initial begin
    sv[0] = '{1'b1, 48'd1, 1'b1, 1'b0, 48'd0};
    sv[1] = '{1'b1, 48'd2, 1'b1, 1'b1, 48'd1};
    sv[2] = '{1'b1, 48'd3, 1'b1, 1'b1, 48'd2};
    sv[3] = '{1'b1, 48'd4, 1'b1, 1'b1, 48'd3};
    sv[4] = '{1'b1, 48'd5, 1'b1, 1'b1, 48'd4};
    sv[5] = '{1'b0, 48'd0, 1'b1, 1'b1, 48'd5};
    sv[6] = '{1'b0, 48'd0, 1'b1, 1'b0, 48'd0};

    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_occ2", 64'(occ2), 64'd0);
    chk("rst_occ3", 64'(occ3), 64'd0);
    chk("rst_ov2", 64'(ov2), 64'd0);
    chk("rst_ov3", 64'(ov3), 64'd0);
    chk("rst_out_zero", 64'(|{out2, out3}), 64'd0);
    rst_n = 1'b1;

    // Streaming through depth 2 with out_ready held high
    or2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iv2 = sv[i].iv;
      if (sv[i].iv) in_b = make_bundle(sv[i].xv);
      #1;
      chk($sformatf("stream_ready[%0d]", i), 64'(ir2), 64'(sv[i].exp_ready));
      tick();
      chk($sformatf("stream_valid[%0d]", i), 64'(ov2), 64'(sv[i].exp_valid));
      if (sv[i].exp_valid)
        chk_b($sformatf("stream_bundle[%0d]", i), out2, make_bundle(sv[i].exp_x));
    end
    iv2 = 1'b0;

    // Backpressure on depth 3: four offered, three fit
    or3 = 1'b0;
    next_x = 10;
    accepted = 0;
    in_b = make_bundle(48'(next_x));
    iv3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      acc = ir3;
      tick();
      if (acc) begin
        accepted++;
        next_x++;
        in_b = make_bundle(48'(next_x));
      end
    end
    chk("bp_accepted", 64'(accepted), 64'd3);
    chk("bp_occ", 64'(occ3), 64'd3);
    chk("bp_in_ready", 64'(ir3), 64'd0);
    chk("bp_out_valid", 64'(ov3), 64'd1);
    chk_b("bp_head", out3, make_bundle(48'd10));

    // Full pipe, out_ready rises: accept and emit in the same cycle
    or3 = 1'b1;
    #1;
    chk("full_in_ready", 64'(ir3), 64'd1);
    emitted = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov3) begin
        chk_b($sformatf("drain[%0d]", emitted), out3, make_bundle(48'(10 + emitted)));
        emitted++;
      end
      acc = ir3 && iv3;
      tick();
      if (acc) iv3 = 1'b0;
    end
    chk("drain_count", 64'(emitted), 64'd4);

    // Bubble collapse with a single bundle under backpressure
    flush = 1'b1;
    tick();
    flush = 1'b0;
    or3 = 1'b0;
    in_b = make_bundle(48'd20);
    iv3 = 1'b1;
    tick();
    iv3 = 1'b0;
    chk("bub_ov_1", 64'(ov3), 64'd0);
    chk("bub_ready_1", 64'(ir3), 64'd1);
    chk("bub_occ_1", 64'(occ3), 64'd1);
    tick();
    chk("bub_ov_2", 64'(ov3), 64'd0);
    chk("bub_ready_2", 64'(ir3), 64'd1);
    tick();
    chk("bub_ov_3", 64'(ov3), 64'd1);
    chk("bub_ready_3", 64'(ir3), 64'd1);
    chk_b("bub_bundle", out3, make_bundle(48'd20));

    // Seven stalled cycles with the head held bit-exact
    for (int c = 0; c < 7; c++) tick();
    chk_b("stall_hold", out3, make_bundle(48'd20));
`ifdef DENSE_PIPE_PERF_EN
    chk("perf_stall7", 64'(sc3), 64'd7);
`endif

    // Flush with occupancy 2 and a same-cycle offer
    in_b = make_bundle(48'd21);
    iv3 = 1'b1;
    tick();
    chk("fl_occ_pre", 64'(occ3), 64'd2);
    in_b = make_bundle(48'd99);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(ir3), 64'd1);
    tick();
    flush = 1'b0;
    iv3 = 1'b0;
    chk("fl_occ", 64'(occ3), 64'd0);
    chk("fl_ov", 64'(ov3), 64'd0);
`ifdef DENSE_PIPE_PERF_EN
    chk("fl_stall_clr", 64'(sc3), 64'd0);
`endif
    or3 = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (ov3) seen++;
      tick();
    end
    chk("fl_dropped", 64'(seen), 64'd0);

    // Asynchronous reset mid-stream, checked before any clock edge
    or2 = 1'b1;
    or3 = 1'b0;
    in_b = make_bundle(48'd30);
    iv2 = 1'b1;
    iv3 = 1'b1;
    tick();
    tick();
    tick();
    chk("ar_pre_ov2", 64'(ov2), 64'd1);
    chk("ar_pre_ov3", 64'(ov3), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov2", 64'(ov2), 64'd0);
    chk("ar_ov3", 64'(ov3), 64'd0);
    chk("ar_occ2", 64'(occ2), 64'd0);
    chk("ar_occ3", 64'(occ3), 64'd0);
    chk("ar_out_zero", 64'(|{out2, out3}), 64'd0);
`ifdef DENSE_PIPE_PERF_EN
    chk("ar_stall3", 64'(sc3), 64'd0);
`endif
    iv3 = 1'b0;
    in_b = make_bundle(48'd40);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_first_accept", 64'(occ2), 64'd1);
    iv2 = 1'b0;
    tick();
    chk("ar_post_ov", 64'(ov2), 64'd1);
    chk_b("ar_post_bundle", out2, make_bundle(48'd40));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dense_layer_pipe_reg.md
DENSE_LAYER_PIPE_REG -- requirements
Module: dense_layer_pipe_reg

Interface
REQ-001 SHALL have parameter size, default 3, number of data lanes per vector.
REQ-002 SHALL have parameter data_size, default 16, bits per lane.
REQ-003 SHALL have parameters cost_type_size 8, dense_type_size 4, act_type_size 4, widths of the matching fields.
REQ-004 SHALL have parameter depth, default 2, pipeline stage count; legal range 1..16.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have ports act_type, backprop_cost, cost_type, is_update, predict_value, w_layer_index[31:0], w_row_index[31:0], dense_type, x, w, all inputs; predict_value, x and w are data_size*size bits each.
REQ-008 SHALL have a matching output for each REQ-007 field, named <field>_out.
REQ-009 SHALL have ports in_valid (in, 1), in_ready (out, 1), out_valid (out, 1), out_ready (in, 1), forming a valid/ready handshake.
REQ-010 SHALL have port flush, input, 1, synchronous pipeline clear.
REQ-011 SHALL have port occupancy, output, $clog2(depth+1), count of valid stages.

Function
REQ-012 SHALL carry the full field bundle through depth stages, each holding a valid bit and a bundle register.
REQ-013 SHALL accept a bundle when in_valid and in_ready are both 1 at a clock edge, and emit one when out_valid and out_ready are both 1.
REQ-014 SHALL make stage k ready when it is empty or stage k+1 (or the output, for the last stage) is ready; in_ready = stage-0 ready, combinational.
REQ-015 SHALL collapse bubbles: a valid stage advances into an empty downstream stage even while out_ready = 0.
REQ-016 SHALL have latency exactly depth cycles from acceptance to out_valid when no stall occurs, and throughput of one bundle per cycle.
REQ-017 SHALL hold a stalled stage's bundle bit-exact; no bundle is duplicated, dropped or reordered.
REQ-018 SHALL drive *_out and out_valid directly from the last stage, with no combinational path from inputs.
REQ-019 SHALL, on flush = 1, clear every valid bit at that edge; a bundle offered in the same cycle is dropped, and in_ready is not gated by flush.
REQ-020 SHALL update occupancy each cycle as the registered count of valid stages; full when occupancy = depth.
REQ-021 SHALL, when full and out_ready = 1, accept one input and emit one output in the same cycle.

Reset
REQ-022 SHALL, while rst_n = 0, clear all valid bits and bundle registers to 0, giving out_valid = 0, all *_out = 0 and occupancy = 0.
REQ-023 SHALL treat assertion mid-transfer as a full discard; the first acceptance can occur at the first edge after rst_n rises.

Configuration
REQ-024 SHALL, with DENSE_PIPE_PERF_EN defined, add a 32-bit output stall_count.
REQ-025 stall_count SHALL increment on each cycle with out_valid = 1 and out_ready = 0, saturate at all-ones, and clear on reset or flush.
REQ-026 SHALL, without DENSE_PIPE_PERF_EN, omit the stall_count port and its logic entirely.

Structure
REQ-027 SHALL keep the field-width defaults, a bundle-width function and the bundle packing order in shared package dense_pkg.
REQ-028 SHALL use packing order act_type, backprop_cost, cost_type, is_update, predict_value, w_layer_index, w_row_index, dense_type, x, w, MSB first.
REQ-029 SHALL instantiate depth copies of sub-module dense_pipe_stage, parametrised by bundle width, each holding the valid bit, payload and ready logic.

Verification
REQ-030 Streaming test: depth=2, out_ready=1, send bundles with x=1..5 on consecutive cycles -> out_valid from cycle 2, x_out=1..5 in order, in_ready stays 1.
REQ-031 Backpressure test: depth=3, out_ready=0, send 4 bundles -> 3 accepted, occupancy=3, in_ready=0; raise out_ready -> all 4 emerge in order.
REQ-032 Bubble test: depth=3, single bundle, out_ready=0 -> out_valid after 3 cycles, and in_ready stays 1 until occupancy=3.
REQ-033 Flush test: occupancy=2 plus in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0, offered bundle never appears.
REQ-034 Reset test: rst_n low mid-stream, asynchronously with no clock edge -> out_valid=0, *_out=0, occupancy=0 immediately; stall_count=0 when PERF_EN is defined.
REQ-035 Perf test (PERF_EN): hold out_ready=0 for 7 cycles with out_valid=1 -> stall_count=7.
